muldiv_sequencer: RTL

Iterative multiply/divide sequencer that replaces the single-cycle combinational multiply/divide unit beside the ALU in the CPU datapath. It accepts one HI/LO operation per request and runs a shift-add multiply or a restoring divide over N cycles. It holds the HI/LO architectural registers and gives the CPU a stall signal so the PC and register-file write are frozen while it is busy. MTHI/MTLO moves complete in one cycle.

---
 rtl/muldiv_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative HI/LO multiply/divide unit with CPU stall.
// Shift-add multiply and restoring divide, one step per cycle over N cycles,
// followed by a single FIX cycle that applies sign correction and writes HI/LO.
// MTHI/MTLO complete in one cycle without leaving IDLE.
// Optional feature macro: MULDIV_SIGNED_EN (signed MULT/DIV with sign tracking).
module muldiv_sequencer #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         stall,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    // Multiply: {partial high, multiplier/product low}. Divide: {remainder, dividend/quotient}.
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   m_q, m_d;
    logic [N-1:0]   a_raw_q, a_raw_d;
    logic           is_div_q, is_div_d;
    logic           div0_q, div0_d;
    logic [N-1:0]   hi_d, lo_d;
    logic           done_d;
`ifdef MULDIV_SIGNED_EN
    logic           neg_res_q, neg_res_d;
    logic           neg_rem_q, neg_rem_d;
    logic           sign_a, sign_b;
`endif

    logic [N-1:0]   abs_a, abs_b;
    logic [N:0]     sum;
    logic [N:0]     shifted;
    logic [N:0]     diff;
    logic [2*N-1:0] prod;
    logic [N-1:0]   quo, rem;

    assign busy  = (state_q != IDLE);
    assign stall = busy | (start & ~op[2] & (state_q == IDLE));

    // Next-state, datapath step and HI/LO write selection.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        m_d      = m_q;
        a_raw_d  = a_raw_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        hi_d     = hi;
        lo_d     = lo;
        done_d   = 1'b0;
`ifdef MULDIV_SIGNED_EN
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        sign_a    = op[0] & a[N-1];
        sign_b    = op[0] & b[N-1];
        abs_a     = a;
        abs_b     = b;
        if (sign_a) abs_a = -a;
        if (sign_b) abs_b = -b;
`else
        abs_a     = a;
        abs_b     = b;
`endif

        // Single step of each algorithm, used only in RUN.
        sum     = {1'b0, acc_q[2*N-1:N]} + {1'b0, (acc_q[0] ? m_q : {N{1'b0}})};
        shifted = acc_q[2*N-1:N-1];
        diff    = shifted - {1'b0, m_q};

        // Sign-corrected results, used only in FIX.
        prod = acc_q;
        quo  = acc_q[N-1:0];
        rem  = acc_q[2*N-1:N];
`ifdef MULDIV_SIGNED_EN
        if (neg_res_q) begin
            prod = -acc_q;
            quo  = -acc_q[N-1:0];
        end
        if (neg_rem_q) rem = -acc_q[2*N-1:N];
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        is_div_d = op[1];
                        div0_d   = op[1] & (b == '0);
                        a_raw_d  = a;
                        // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
                        m_d      = op[1] ? abs_b : abs_a;
                        acc_d    = {{N{1'b0}}, (op[1] ? abs_a : abs_b)};
                        count_d  = CW'(N - 1);
                        state_d  = RUN;
`ifdef MULDIV_SIGNED_EN
                        neg_res_d = sign_a ^ sign_b;
                        neg_rem_d = sign_a;
`endif
                    end else if (!op[1]) begin
                        if (op[0]) lo_d = a;
                        else       hi_d = a;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (is_div_q) begin
                    if (!diff[N]) acc_d = {diff[N-1:0], acc_q[N-2:0], 1'b1};
                    else          acc_d = {shifted[N-1:0], acc_q[N-2:0], 1'b0};
                end else begin
                    acc_d = {sum, acc_q[N-1:1]};
                end
                if (count_q == '0) state_d = FIX;
                else               count_d = count_q - CW'(1);
            end
            FIX: begin
                if (is_div_q) begin
                    if (div0_q) begin
                        lo_d = '1;
                        hi_d = a_raw_q;
                    end else begin
                        lo_d = quo;
                        hi_d = rem;
                    end
                end else begin
                    hi_d = prod[2*N-1:N];
                    lo_d = prod[N-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, working registers and architectural HI/LO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            a_raw_q   <= a_raw_d;
            is_div_q  <= is_div_d;
            div0_q    <= div0_d;
            hi        <= hi_d;
            lo        <= lo_d;
            done      <= done_d;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

endmodule
